pcs_sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for the PCS RX datapath. It buffers 66-bit blocks between the descrambler/block-sync stage and the decoder when both run on the same clock. It extends the plain dual-port memory with:
- pointer management and full/empty flags
- an occupancy count and programmable almost-full/almost-empty thresholds
- sticky overflow/underflow flags and a synchronous flush

Read data is show-ahead (first-word fall-through).

---
 rtl/pcs_sync_fifo.sv | 95 +++++++++
 tb/tb_pcs_sync_fifo.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pcs_sync_fifo.sv
// rtl/pcs_sync_fifo.sv - single-clock show-ahead FIFO for 66-bit PCS RX blocks
module pcs_sync_fifo #(
  parameter int DATASIZE  = 66,
  parameter int ADDRSIZE  = 3,
  parameter int AFULL_TH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   level,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] LVL_FULL = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] LVL_AF   = (ADDRSIZE+1)'(AFULL_TH);
  localparam logic [ADDRSIZE:0] LVL_AE   = (ADDRSIZE+1)'(AEMPTY_TH);

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [ADDRSIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDRSIZE:0]   level_q, level_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                wr_ok, rd_ok, wr_en, rd_en;

  // Status flags decode only from the registered level, never from winc/rinc.
  assign wfull         = (level_q == LVL_FULL);
  assign rempty        = (level_q == '0);
  assign walmost_full  = (level_q >= LVL_AF);
  assign ralmost_empty = (level_q <= LVL_AE);
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;
  assign rdata         = mem_q[rptr_q];

  // A pop at full frees the slot the write lands in, so both are accepted.
  assign wr_ok = winc & (~wfull | rinc);
  assign rd_ok = rinc & ~rempty;
  assign wr_en = wr_ok & ~flush;
  assign rd_en = rd_ok & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ADDRSIZE'(1);
      if (rd_en) rptr_d = rptr_q + ADDRSIZE'(1);
      level_d = level_q + (ADDRSIZE+1)'(wr_en) - (ADDRSIZE+1)'(rd_en);
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    ovf_d = ovf_q & ~clr_err;
    unf_d = unf_q & ~clr_err;
    if (!flush && winc && wfull && !rinc) ovf_d = 1'b1;
    if (!flush && rinc && rempty)         unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: tb/tb_pcs_sync_fifo.sv
// tb/tb_pcs_sync_fifo.sv - randomized queue-model bench for pcs_sync_fifo
module tb_pcs_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        winc = 1'b0;
  logic [65:0] wdata = '0;
  logic        rinc = 1'b0;
  logic [65:0] rdata;
  logic        wfull, rempty, walmost_full, ralmost_empty;
  logic [3:0]  level;
  logic        overflow, underflow;
  logic        clr_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [65:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  pcs_sync_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .rinc(rinc), .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .ralmost_empty(ralmost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".level"}, 66'(level), 66'(n));
    check({tag, ".wfull"}, 66'(wfull), 66'(n == 8));
    check({tag, ".rempty"}, 66'(rempty), 66'(n == 0));
    check({tag, ".afull"}, 66'(walmost_full), 66'(n >= 6));
    check({tag, ".aempty"}, 66'(ralmost_empty), 66'(n <= 2));
    check({tag, ".ovf"}, 66'(overflow), 66'(m_ovf));
    check({tag, ".unf"}, 66'(underflow), 66'(m_unf));
    if (n > 0) check({tag, ".rdata"}, rdata, mq[0]);
  endtask

  // Drive one cycle of requests, advance the queue model, then check after the edge.
  task automatic cycle(input string tag, input bit w, input bit r, input logic [65:0] d,
                       input bit f = 1'b0, input bit c = 1'b0);
    bit full, empty, o_set, u_set;
    winc = w; rinc = r; wdata = d; flush = f; clr_err = c;
    if (mq.size() > 0) check({tag, ".head_pre"}, rdata, mq[0]);
    full  = (mq.size() == 8);
    empty = (mq.size() == 0);
    o_set = !f && w && full && !r;
    u_set = !f && r && empty;
    m_ovf = o_set || (m_ovf && !c);
    m_unf = u_set || (m_unf && !c);
    if (f) begin
      mq.delete();
    end else begin
      if (r && !empty) void'(mq.pop_front());
      if (w && (!full || r)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [65:0] rnd;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, 66'(i));
    cycle("ovf", 1'b1, 1'b0, 66'h9);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1, '0);
    cycle("clr", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 1; i <= 8; i++) cycle("fill2", 1'b1, 1'b0, 66'(i + 16));
    cycle("full_wr_rd", 1'b1, 1'b1, 66'hA);
    for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, 1'b1, '0);

    cycle("empty_wr_rd", 1'b1, 1'b1, 66'h5);
    check("empty_wr_rd.data5", rdata, 66'h5);
    cycle("pop5", 1'b0, 1'b1, '0);

    cycle("prime", 1'b1, 1'b0, 66'h3C);
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 1'b1, 66'(i));
    cycle("stream_end", 1'b0, 1'b1, '0);

    for (int i = 0; i < 5; i++) cycle("pre_flush", 1'b1, 1'b0, 66'(i + 40));
    cycle("flush", 1'b1, 1'b1, 66'h77, 1'b1);
    for (int i = 0; i < 3; i++) cycle("refill", 1'b1, 1'b0, 66'(i + 50));
    cycle("set_ovf_fill", 1'b1, 1'b0, 66'h60);
    #3;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 600; k++) begin
      rnd = {$urandom, $urandom, $urandom};
      cycle("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), rnd,
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
